// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the timing generator,
// color mapper and ball/paddle logic.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Half-open window test: lo <= c < hi.
  function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
    return (c >= COORD_W'(lo)) && (c < COORD_W'(hi));
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v counters, and an
// output stage that keeps sync, blank and color aligned on the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COLOR_W-1:0] Red,
  input  logic [COLOR_W-1:0] Green,
  input  logic [COLOR_W-1:0] Blue,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK,
  output logic               frame_end
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic   pix_en;
  coord_t h;
  coord_t v;

  logic h_last_c;
  logic v_last_c;
  logic v_vis_last_c;
  logic h_sync_c;
  logic v_sync_c;
  logic visible_c;

  assign h_last_c     = (h == COORD_W'(H_TOTAL - 1));
  assign v_last_c     = (v == COORD_W'(V_TOTAL - 1));
  assign v_vis_last_c = (v == COORD_W'(V_VISIBLE - 1));
  assign h_sync_c     = in_window(h, H_SYNC_START, H_SYNC_END);
  assign v_sync_c     = in_window(v, V_SYNC_START, V_SYNC_END);
  assign visible_c    = (h < COORD_W'(H_VISIBLE)) && (v < COORD_W'(V_VISIBLE));

  // Divide-by-two pixel enable and raster counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_last_c) begin
          h <= '0;
          v <= v_last_c ? '0 : v + COORD_W'(1);
        end else begin
          h <= h + COORD_W'(1);
        end
      end
    end
  end

  // Pin stage samples the pixel being left, so all pins share one pixel of latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= ~h_sync_c;
      VGA_VS      <= ~v_sync_c;
      VGA_BLANK_N <= visible_c;
      VGA_R       <= visible_c ? Red   : '0;
      VGA_G       <= visible_c ? Green : '0;
      VGA_B       <= visible_c ? Blue  : '0;
    end
  end

  // One-Clk pulse as the raster steps from the last visible line into blanking.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_end <= 1'b0;
    end else begin
      frame_end <= pix_en & h_last_c & v_vis_last_c;
    end
  end

  assign DrawX      = h;
  assign DrawY      = v;
  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-color bench for vga_timing_gen: a shrunk-timing instance checked
// over several frames and a reset, plus a default 640x480 instance over a few lines.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int unsigned SHV = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int unsigned SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int unsigned S_HT = SHV + SHF + SHS + SHB;
  localparam int unsigned S_VT = SVV + SVF + SVS + SVB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pclk;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       fe;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  logic [7:0] Red, Green, Blue;

  logic [9:0] s_x, s_y, b_x, b_y;
  logic [7:0] s_r, s_g, s_b, b_r, b_g, b_b;
  logic s_hs, s_vs, s_bn, s_sn, s_pclk, s_fe;
  logic b_hs, b_vs, b_bn, b_sn, b_pclk, b_fe;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .Clk(Clk), .Reset(Reset), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(s_x), .DrawY(s_y), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn),
    .VGA_CLK(s_pclk), .frame_end(s_fe)
  );

  vga_timing_gen u_big (
    .Clk(Clk), .Reset(Reset), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(b_x), .DrawY(b_y), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn),
    .VGA_CLK(b_pclk), .frame_end(b_fe)
  );

  always #5 Clk = ~Clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected state after k Clk edges since reset, from raster arithmetic:
  // pixel n = k/2 is on the counters, pixel n-1 is on the pins.
  function automatic exp_t model(input int unsigned k,
                                 input int unsigned hv, input int unsigned hf,
                                 input int unsigned hsw, input int unsigned hb,
                                 input int unsigned vv, input int unsigned vf,
                                 input int unsigned vsw, input int unsigned vb);
    int unsigned ht, vt, n, p, hp, vp;
    exp_t e;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    n  = k / 2;
    e.x    = 10'(n % ht);
    e.y    = 10'((n / ht) % vt);
    e.pclk = 1'(k % 2);
    if (n == 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bn = 1'b0;
    end else begin
      p  = n - 1;
      hp = p % ht;
      vp = (p / ht) % vt;
      e.hs = !((hp >= hv + hf) && (hp < hv + hf + hsw));
      e.vs = !((vp >= vv + vf) && (vp < vv + vf + vsw));
      e.bn = (hp < hv) && (vp < vv);
    end
    e.fe = (k >= 2) && (k % 2 == 0) && (n % (ht * vt) == ht * vv);
    return e;
  endfunction

  int unsigned k   = 0;
  int unsigned cyc = 0;
  logic [23:0] samp = '0;

  // Edge counter since reset and the color the DUT should have captured.
  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      k = 0;
    end else begin
      k++;
      if (k % 2 == 0) samp = {Red, Green, Blue};
    end
  end

  logic chk_en = 1'b0;
  logic big_en = 1'b0;
  logic fe_first = 1'b1;
  int unsigned last_fe = 0;
  int unsigned hs_low = 0, bn_high = 0;
  logic hs_fell = 1'b0;

  always @(negedge Clk) begin
    exp_t es, eb;
    if (chk_en) begin
      es = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
      check("s_xy",    {s_x, s_y}, {es.x, es.y});
      check("s_pclk",  s_pclk, es.pclk);
      check("s_pins",  {s_hs, s_vs, s_bn, s_sn}, {es.hs, es.vs, es.bn, 1'b0});
      check("s_fe",    s_fe, es.fe);
      check("s_rgb",   {s_r, s_g, s_b}, es.bn ? samp : 24'h0);
      if (k == 0) fe_first = 1'b1;
      if (s_fe) begin
        if (fe_first) check("s_fe_first", k, 2 * S_HT * SVV);
        else          check("s_fe_period", cyc - last_fe, 2 * S_HT * S_VT);
        fe_first = 1'b0;
        last_fe  = cyc;
      end
      if (big_en) begin
        eb = model(k, H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
                   V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
        check("b_xy",   {b_x, b_y}, {eb.x, eb.y});
        check("b_pclk", b_pclk, eb.pclk);
        check("b_pins", {b_hs, b_vs, b_bn, b_sn}, {eb.hs, eb.vs, eb.bn, 1'b0});
        check("b_fe",   b_fe, eb.fe);
        check("b_rgb",  {b_r, b_g, b_b}, eb.bn ? samp : 24'h0);
        // Line 0 occupies the pins for edges 2..1601.
        if (k >= 2 && k <= 1601) begin
          hs_low  += (b_hs == 1'b0) ? 1 : 0;
          bn_high += (b_bn == 1'b1) ? 1 : 0;
        end
        if (k == 1601) begin
          check("b_hs_low_clks", hs_low, 192);
          check("b_blank_clks", bn_high, 1280);
        end
        if (!b_hs && !hs_fell && k > 0) begin
          check("b_hs_fall_edge", k, 2 * 656 + 2);
          hs_fell = 1'b1;
        end
      end
    end
  end

  task automatic run(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge Clk);
      Red   = 8'($urandom);
      Green = 8'($urandom);
      Blue  = 8'($urandom);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Red   = 8'hAA;
    Green = 8'h55;
    Blue  = 8'hFF;
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    big_en = 1'b1;
    Reset  = 1'b0;
    run(5000);
    big_en = 1'b0;
    // k = 5000 lands mid-frame on the small raster (h=10, v=7).
    Reset = 1'b1;
    run(3);
    Reset = 1'b0;
    run(3100);
    check("s_fe_seen_after_reset", fe_first, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
